// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one data-memory access per load/store and fills the MEM/WB register.
// Latency: non-memory and misaligned ops retire on the next edge; stores one edge after gnt; loads one edge after rvalid.
// Backpressure: stall holds upstream during an aligned access's accept cycle and until that access completes.
module mem_stage_lsu #(
    parameter int XLEN      = 32,
    parameter int WB_CTRL_W = 3,
    parameter int RD_W      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [2:0]           funct3,
    input  logic [WB_CTRL_W-1:0] ctrl_wb_in,
    input  logic [RD_W-1:0]      rd_in,
    input  logic [XLEN-1:0]      pc4_in,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [XLEN-1:0]      store_data,
    output logic                 stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN/8-1:0]    dmem_be,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 wb_valid,
    output logic [WB_CTRL_W-1:0] ctrl_wb,
    output logic [RD_W-1:0]      rd_wb,
    output logic [XLEN-1:0]      pc4_wb,
    output logic [XLEN-1:0]      mem_data,
    output logic [XLEN-1:0]      alu_data,
    output logic                 misalign
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
    state_t state;

    // Decoded view of the incoming instruction
    logic            is_mem;
    logic            misaligned_in;
    logic [OFF_W-1:0] off_in;
    logic [NB-1:0]   be_in;
    logic [XLEN-1:0] wdata_in;

    // Fields captured at accept so the access does not depend on upstream holding its inputs
    logic                 store_q;
    logic [2:0]           funct3_q;
    logic [OFF_W-1:0]     off_q;
    logic [WB_CTRL_W-1:0] ctrl_q;
    logic [RD_W-1:0]      rd_q;
    logic [XLEN-1:0]      pc4_q;
    logic [XLEN-1:0]      alu_q;

    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_ext;

    // Decode size/alignment, build lane-placed request fields, and extend returning load data
    always_comb begin
        is_mem        = mem_read | mem_write;
        off_in        = alu_result[OFF_W-1:0];
        misaligned_in = 1'b0;
        be_in         = '0;
        wdata_in      = '0;
        case (funct3[1:0])
            2'b00: begin
                be_in    = NB'(1) << off_in;
                wdata_in = {(XLEN/8){store_data[7:0]}};
            end
            2'b01: begin
                misaligned_in = alu_result[0];
                be_in         = NB'(3) << off_in;
                wdata_in      = {(XLEN/16){store_data[15:0]}};
            end
            default: begin
                misaligned_in = |alu_result[1:0];
                be_in         = NB'(15) << off_in;
                wdata_in      = {(XLEN/32){store_data[31:0]}};
            end
        endcase

        // Addressed lane moves to bit 0; the size then picks how much survives
        rdata_shifted = dmem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = XLEN'($signed(rdata_shifted[7:0]));
            3'b001:  load_ext = XLEN'($signed(rdata_shifted[15:0]));
            3'b100:  load_ext = XLEN'(rdata_shifted[7:0]);
            3'b101:  load_ext = XLEN'(rdata_shifted[15:0]);
            default: load_ext = XLEN'(rdata_shifted[31:0]);
        endcase

        // Reset dominates so nothing is requested or held off while it is asserted
        stall    = !reset && ((state == REQ) || (state == WAIT_R) ||
                              ((state == IDLE) && in_valid && is_mem && !misaligned_in));
        dmem_req = !reset && (state == REQ);
        dmem_we  = dmem_req && store_q;
    end

    // Sequencer: accept, hold the request until granted, await read data, and load MEM/WB
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wb_valid   <= 1'b0;
            ctrl_wb    <= '0;
            rd_wb      <= '0;
            pc4_wb     <= '0;
            mem_data   <= '0;
            alu_data   <= '0;
            misalign   <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            store_q    <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            pc4_q      <= '0;
            alu_q      <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem || misaligned_in) begin
                            // Retires immediately; a misaligned access is squashed to no writeback
                            wb_valid <= 1'b1;
                            ctrl_wb  <= is_mem ? '0 : ctrl_wb_in;
                            rd_wb    <= rd_in;
                            pc4_wb   <= pc4_in;
                            alu_data <= alu_result;
                            mem_data <= '0;
                            misalign <= is_mem;
                        end else begin
                            state      <= REQ;
                            dmem_addr  <= {alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            dmem_be    <= be_in;
                            dmem_wdata <= wdata_in;
                            store_q    <= mem_write;
                            funct3_q   <= funct3;
                            off_q      <= off_in;
                            ctrl_q     <= ctrl_wb_in;
                            rd_q       <= rd_in;
                            pc4_q      <= pc4_in;
                            alu_q      <= alu_result;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        if (store_q) begin
                            state    <= IDLE;
                            wb_valid <= 1'b1;
                            ctrl_wb  <= ctrl_q;
                            rd_wb    <= rd_q;
                            pc4_wb   <= pc4_q;
                            alu_data <= alu_q;
                            mem_data <= '0;
                            misalign <= 1'b0;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        ctrl_wb  <= ctrl_q;
                        rd_wb    <= rd_q;
                        pc4_wb   <= pc4_q;
                        alu_data <= alu_q;
                        mem_data <= load_ext;
                        misalign <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed ops, a retirement scoreboard, and literal pins.
// Latency: checks retirement timing via a per-cycle wb_valid history.
// Backpressure: the bench acts as upstream (holds inputs while stalled) and as the memory (gnt/rvalid).
module tb_mem_stage_lsu;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [2:0]  ctrl_wb_in;
    logic [4:0]  rd_in;
    logic [31:0] pc4_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [2:0]  ctrl_wb;
    logic [4:0]  rd_wb;
    logic [31:0] pc4_wb;
    logic [31:0] mem_data;
    logic [31:0] alu_data;
    logic        misalign;

    mem_stage_lsu #(.XLEN(32), .WB_CTRL_W(3), .RD_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .ctrl_wb_in(ctrl_wb_in), .rd_in(rd_in),
        .pc4_in(pc4_in), .alu_result(alu_result), .store_data(store_data), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .ctrl_wb(ctrl_wb), .rd_wb(rd_wb),
        .pc4_wb(pc4_wb), .mem_data(mem_data), .alu_data(alu_data), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] mem;
        logic [31:0] alu;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    logic        wb_hist[$];
    int          stall_cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          op_n = 0;
    logic [31:0] last_req_addr;
    logic [3:0]  last_req_be;
    logic [31:0] last_req_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference load result: pick the addressed byte/half/word and extend by plain arithmetic
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * int'(addr[1:0]));
        case (f3)
            3'b000: begin v = v % 32'd256;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'b001: begin v = v % 32'd65536; if (v >= 32'd32768) v = v - 32'd65536; end
            3'b100: v = v % 32'd256;
            3'b101: v = v % 32'd65536;
            default: v = rdata;
        endcase
        return v;
    endfunction

    // Per-cycle compare: every retirement must match the oldest pending expectation
    always @(negedge clk) begin
        wb_hist.push_back(wb_valid);
        if (stall === 1'b1) stall_cnt++;
        if (reset === 1'b1) begin
            check("reset_stall", 32'(stall), 32'd0);
            check("reset_req", 32'(dmem_req), 32'd0);
        end else if (wb_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_retire", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_ctrl", 32'(ctrl_wb), 32'(e.ctrl));
                check("wb_rd", 32'(rd_wb), 32'(e.rd));
                check("wb_pc4", pc4_wb, e.pc4);
                check("wb_mem_data", mem_data, e.mem);
                check("wb_alu_data", alu_data, e.alu);
                check("wb_misalign", 32'(misalign), 32'(e.mis));
            end
        end
    end

    // Upstream + memory model for one instruction; leaves the bench at posedge+1 of its retire edge
    task automatic run_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                          input int gnt_dly, input logic rv_with_gnt, input logic [4:0] rd);
        exp_t        e;
        logic        is_mem;
        logic        mis;
        int          size;
        int          off;
        logic [3:0]  exp_be;
        logic [31:0] bm;
        is_mem = rd_op | wr_op;
        size   = 1 << f3[1:0];
        off    = int'(addr[1:0]);
        mis    = is_mem && ((addr[1:0] & 2'(size - 1)) != 2'b00);
        exp_be = 4'(((1 << size) - 1) << off);
        bm     = '0;
        for (int b = 0; b < 4; b++) if (exp_be[b]) bm[8*b +: 8] = 8'hFF;

        e.ctrl = mis ? 3'd0 : 3'(op_n * 3 + 1);
        e.rd   = rd;
        e.pc4  = 32'h1000 + 32'(op_n) * 4;
        e.alu  = addr;
        e.mis  = mis;
        e.mem  = (rd_op && !mis) ? model_load(f3, addr, rdata) : 32'd0;
        exp_q.push_back(e);

        in_valid   = 1'b1;
        mem_read   = rd_op;
        mem_write  = wr_op;
        funct3     = f3;
        ctrl_wb_in = 3'(op_n * 3 + 1);
        rd_in      = rd;
        pc4_in     = e.pc4;
        alu_result = addr;
        store_data = sd;
        op_n++;

        @(negedge clk);
        check("accept_stall", 32'(stall), 32'(is_mem && !mis));
        check("idle_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        if (!is_mem || mis) begin
            in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            return;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            if (i == gnt_dly) begin
                dmem_gnt = 1'b1;
                if (rv_with_gnt) begin dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111; end
            end
            @(negedge clk);
            check("req_valid", 32'(dmem_req), 32'd1);
            check("req_we", 32'(dmem_we), 32'(wr_op));
            check("req_addr", dmem_addr, {addr[31:2], 2'b00});
            check("req_be", 32'(dmem_be), 32'(exp_be));
            if (wr_op) check("req_wdata", dmem_wdata & bm, (sd << (8 * off)) & bm);
            check("req_stall", 32'(stall), 32'd1);
            last_req_addr  = dmem_addr;
            last_req_be    = dmem_be;
            last_req_wdata = dmem_wdata;
            @(posedge clk); #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        end
        if (!wr_op) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            @(negedge clk);
            check("wait_req", 32'(dmem_req), 32'd0);
            check("wait_stall", 32'(stall), 32'd1);
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
        end
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int n0;
        int s0;
        logic [5:0] pat;
        reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        ctrl_wb_in = 3'd0; rd_in = 5'd0; pc4_in = 32'd0; alu_result = 32'd0; store_data = 32'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_ctrl", 32'(ctrl_wb), 32'd0);
        check("rst_rd", 32'(rd_wb), 32'd0);
        check("rst_pc4", pc4_wb, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_alu_data", alu_data, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Plain ALU op retires next cycle, never stalls
        s0 = stall_cnt;
        run_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'd0, 32'd0, 0, 1'b0, 5'd7);
        check("alu_wb_valid", 32'(wb_valid), 32'd1);
        check("alu_data_lit", alu_data, 32'h0000_1234);
        check("alu_rd_lit", 32'(rd_wb), 32'd7);
        check("alu_no_stall", 32'(stall_cnt - s0), 32'd0);

        // LB / LBU at 0x103 with a delayed grant
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_FFFF, 2, 1'b0, 5'd1);
        check("lb_addr_lit", last_req_addr, 32'h100);
        check("lb_be_lit", 32'(last_req_be), 32'b1000);
        check("lb_data_lit", mem_data, 32'hFFFF_FF80);
        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_FFFF, 2, 1'b0, 5'd2);
        check("lbu_data_lit", mem_data, 32'h0000_0080);

        // SH into the upper half
        run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'd0, 1, 1'b0, 5'd3);
        check("sh_be_lit", 32'(last_req_be), 32'b1100);
        check("sh_wdata_lit", last_req_wdata & 32'hFFFF_0000, 32'hABCD_0000);
        check("sh_retire", 32'(wb_valid), 32'd1);

        // Misaligned word load: no request, flagged, writeback squashed
        run_op(1'b1, 1'b0, 3'b010, 32'h006, 32'd0, 32'd0, 0, 1'b0, 5'd4);
        check("lw_mis_flag", 32'(misalign), 32'd1);
        check("lw_mis_ctrl", 32'(ctrl_wb), 32'd0);

        // Other sizes, lanes and misalignment cases
        run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'h8001_1234, 0, 1'b0, 5'd5);
        check("lh_data_lit", mem_data, 32'hFFFF_8001);
        run_op(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h8001_1234, 1, 1'b0, 5'd6);
        run_op(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'hDEAD_BEEF, 0, 1'b0, 5'd8);
        run_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_005A, 32'd0, 0, 1'b0, 5'd9);
        check("sb_be_lit", 32'(last_req_be), 32'b0010);
        run_op(1'b0, 1'b1, 3'b010, 32'h400, 32'h1357_9BDF, 32'd0, 3, 1'b0, 5'd10);
        run_op(1'b1, 1'b0, 3'b001, 32'h101, 32'd0, 32'd0, 0, 1'b0, 5'd11);
        run_op(1'b0, 1'b1, 3'b001, 32'h203, 32'h0000_FFFF, 32'd0, 0, 1'b0, 5'd12);
        // rvalid coincident with gnt must not be taken as the load data
        run_op(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 32'h2222_2222, 0, 1'b1, 5'd13);
        check("rv_gnt_lit", mem_data, 32'h2222_2222);

        // Three ALU ops back-to-back, then an LW with immediate gnt/rvalid
        n0 = wb_hist.size();
        s0 = stall_cnt;
        run_op(1'b0, 1'b0, 3'b000, 32'hA0, 32'd0, 32'd0, 0, 1'b0, 5'd14);
        run_op(1'b0, 1'b0, 3'b000, 32'hA4, 32'd0, 32'd0, 0, 1'b0, 5'd15);
        run_op(1'b0, 1'b0, 3'b000, 32'hA8, 32'd0, 32'd0, 0, 1'b0, 5'd16);
        run_op(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 32'h0BAD_F00D, 0, 1'b0, 5'd17);
        @(negedge clk); #1;
        for (int k = 0; k < 6; k++) pat[5-k] = wb_hist[n0 + 1 + k];
        check("b2b_wb_pattern", 32'(pat), 32'b111001);
        check("b2b_stall_cycles", 32'(stall_cnt - s0), 32'd3);

        // Reset while waiting for read data; the late rvalid must be ignored
        @(posedge clk); #1;
        in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h40;
        rd_in = 5'd20; ctrl_wb_in = 3'd5; pc4_in = 32'h2000;
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_stall", 32'(stall), 32'd0);
            check("post_rst_req", 32'(dmem_req), 32'd0);
            check("post_rst_wb", 32'(wb_valid), 32'd0);
            @(posedge clk); #1;
        end
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("post_rst_wb_final", 32'(wb_valid), 32'd0);
        check("post_rst_ctrl", 32'(ctrl_wb), 32'd0);
        check("post_rst_rd", 32'(rd_wb), 32'd0);
        check("post_rst_pc4", pc4_wb, 32'd0);
        check("post_rst_mem", mem_data, 32'd0);
        check("post_rst_alu", alu_data, 32'd0);
        check("post_rst_mis", 32'(misalign), 32'd0);
        @(posedge clk); #1;
        run_op(1'b0, 1'b0, 3'b000, 32'h77, 32'd0, 32'd0, 0, 1'b0, 5'd21);
        check("post_rst_alu_op", alu_data, 32'h77);

        @(negedge clk);
        @(negedge clk);
        check("pending_retire", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
